// File: rtl/enigma_ctrl_pkg.sv
// Scan-code constants and state encodings shared by the keystroke scheduler.
// Also holds the status-byte classifier used by the PS/2 parser.
package enigma_ctrl_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    typedef enum logic [1:0] {
        P_IDLE,
        P_BREAK,
        P_EXT
    } parse_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_ROTATE,
        S_SETTLE
    } seq_state_e;

    // Controller housekeeping bytes that never represent a key.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_RESEND) || (b == SC_ECHO);
    endfunction

endpackage

// File: rtl/keystroke_fifo.sv
// Small circular keystroke queue with synchronous reset and occupancy count.
// A push into a full queue is accepted only if a pop frees a slot that cycle.
module keystroke_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       drop_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, empty, do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && (!full || pop_i);
    assign do_pop  = pop_i && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= nxt(wr_ptr_q);
            end
            if (do_pop)
                rd_ptr_q <= nxt(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign drop_o  = push_i && full && !pop_i;

endmodule

// File: rtl/keystroke_scheduler.sv
// PS/2 make-code parser feeding a keystroke queue, drained by a sequencer that
// presents each key to the cipher core, captures the ciphertext and steps the rotors.
import enigma_ctrl_pkg::*;

module keystroke_scheduler #(
    parameter int SETTLE_CYCLES = 5000,
    parameter int CORE_LATENCY  = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic [7:0] encoded_data,
    output logic [7:0] plain_scan,
    output logic       rotate,
    output logic [7:0] cipher_data,
    output logic       cipher_valid,
    output logic       busy,
    output logic [2:0] fifo_count,
    output logic       overflow
);

    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int WW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY + 1) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    parse_state_e pstate_q, pstate_d;
    logic [7:0]   held_q, held_d;
    logic         push;

    seq_state_e   seq_q;
    logic [WW-1:0] wait_q;
    logic [SW-1:0] settle_q;
    logic [7:0]   plain_q, cipher_q;
    logic         rotate_q, valid_q, overflow_q;

    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_drop, pop;

    always_comb begin
        pstate_d = pstate_q;
        held_d   = held_q;
        push     = 1'b0;
        if (received_data_en) begin
            case (pstate_q)
                P_IDLE: begin
                    if (received_data == SC_BREAK)
                        pstate_d = P_BREAK;
                    else if (received_data == SC_EXT)
                        pstate_d = P_EXT;
                    else if (!is_status_byte(received_data) && received_data != held_q) begin
                        // Typematic repeats of the held key are filtered here.
                        push   = 1'b1;
                        held_d = received_data;
                    end
                end
                P_BREAK: begin
                    if (received_data == held_q)
                        held_d = 8'h00;
                    pstate_d = P_IDLE;
                end
                P_EXT:   pstate_d = (received_data == SC_BREAK) ? P_BREAK : P_IDLE;
                default: pstate_d = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pstate_q <= P_IDLE;
            held_q   <= 8'h00;
        end else begin
            pstate_q <= pstate_d;
            held_q   <= held_d;
        end
    end

    assign pop = (seq_q == S_IDLE) && (fifo_cnt != '0);

    keystroke_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (received_data),
        .dout_o  (fifo_head),
        .count_o (fifo_cnt),
        .drop_o  (fifo_drop)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            seq_q    <= S_IDLE;
            wait_q   <= '0;
            settle_q <= '0;
            plain_q  <= 8'h00;
            cipher_q <= 8'h00;
            valid_q  <= 1'b0;
            rotate_q <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            rotate_q <= 1'b0;
            case (seq_q)
                S_IDLE: if (pop) begin
                    plain_q <= fifo_head;
                    wait_q  <= WW'(CORE_LATENCY - 1);
                    seq_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        cipher_q <= encoded_data;
                        valid_q  <= 1'b1;
                        seq_q    <= S_CAPTURE;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    rotate_q <= 1'b1;
                    settle_q <= SW'(SETTLE_CYCLES);
                    seq_q    <= S_ROTATE;
                end
                S_ROTATE: seq_q <= S_SETTLE;
                S_SETTLE: begin
                    if (settle_q <= SW'(1)) begin
                        settle_q <= '0;
                        seq_q    <= S_IDLE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                default: seq_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            overflow_q <= 1'b0;
        else if (fifo_drop)
            overflow_q <= 1'b1;
    end

    assign plain_scan   = plain_q;
    assign rotate       = rotate_q;
    assign cipher_data  = cipher_q;
    assign cipher_valid = valid_q;
    assign busy         = (seq_q != S_IDLE);
    assign fifo_count   = 3'(fifo_cnt);
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_keystroke_scheduler.sv
// Bench for keystroke_scheduler: directed byte-sequence table, reset-abort case and
// random traffic, all checked cycle by cycle against a queue-based reference model.
module tb_keystroke_scheduler;

    localparam int CL     = 2;
    localparam int SETTLE = 40;

    logic       CLOCK_50, reset, received_data_en;
    logic [7:0] received_data, encoded_data, plain_scan, cipher_data;
    logic       rotate, cipher_valid, busy, overflow;
    logic [2:0] fifo_count;

    keystroke_scheduler #(
        .SETTLE_CYCLES (SETTLE),
        .CORE_LATENCY  (CL),
        .FIFO_DEPTH    (4)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .encoded_data     (encoded_data),
        .plain_scan       (plain_scan),
        .rotate           (rotate),
        .cipher_data      (cipher_data),
        .cipher_valid     (cipher_valid),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .overflow         (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Cipher core stand-in: f(x) = x ^ 0x4D, output settled CL cycles after the pop cycle.
    logic [7:0] enc_q;
    always @(posedge CLOCK_50) enc_q <= plain_scan ^ 8'h4D;
    assign encoded_data = enc_q;

    int vecs = 0, miscompares = 0;

    // Reference model state.
    int         t = 0;
    logic [7:0] q[$];
    logic       ovf;
    logic [7:0] held;
    bit         after_f0, after_e0;
    int         pop_t = -1000000, ready = 0;
    logic [7:0] pop_key, exp_plain, exp_cd;
    bit         prev_r = 1'b0;

    // Observation counters.
    int         nvalid, nrot, max_cnt;
    bit         got_first;
    logic [7:0] first_cd;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (after_f0) begin
            if (b == held) held = 8'h00;
            after_f0 = 1'b0;
        end else if (after_e0) begin
            after_e0 = 1'b0;
            if (b == 8'hF0) after_f0 = 1'b1;
        end else if (b == 8'hF0) after_f0 = 1'b1;
        else if (b == 8'hE0) after_e0 = 1'b1;
        else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE}) && b != held) begin
            held = b;
            if (q.size() < 4) q.push_back(b);
            else ovf = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [7:0] d);
        reset = r; received_data_en = e; received_data = d;
        @(negedge CLOCK_50);
        if (!(r && !prev_r)) begin
            if (t == pop_t + 1)      exp_plain = pop_key;
            if (t == pop_t + CL + 1) exp_cd = pop_key ^ 8'h4D;
            chk("fifo_count",   {5'b0, fifo_count},   8'(q.size()));
            chk("overflow",     {7'b0, overflow},     {7'b0, ovf});
            chk("busy",         {7'b0, busy},         {7'b0, (t > pop_t && t < ready)});
            chk("cipher_valid", {7'b0, cipher_valid}, {7'b0, (t == pop_t + CL + 1)});
            chk("rotate",       {7'b0, rotate},       {7'b0, (t == pop_t + CL + 2)});
            chk("plain_scan",   plain_scan,           exp_plain);
            chk("cipher_data",  cipher_data,          exp_cd);
            if (cipher_valid === 1'b1) begin
                nvalid++;
                if (!got_first) begin first_cd = cipher_data; got_first = 1'b1; end
            end
            if (rotate === 1'b1) nrot++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        if (r) begin
            q.delete(); ovf = 1'b0; held = 8'h00; after_f0 = 1'b0; after_e0 = 1'b0;
            pop_t = -1000000; ready = 0; exp_plain = 8'h00; exp_cd = 8'h00;
        end else begin
            if (q.size() > 0 && t >= ready) begin
                pop_key = q.pop_front();
                pop_t   = t;
                ready   = t + CL + 3 + SETTLE;
            end
            if (e) model_byte(d);
        end
        prev_r = r;
        t++;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drain();
        int b = 3000;
        while (!(q.size() == 0 && t >= ready) && b > 0) begin
            cyc(1'b0, 1'b0, 8'h00);
            b--;
        end
        vecs++;
        if (b == 0) begin
            miscompares++;
            $display("FAIL drain_timeout t=%0d got=%0d want=0 queued", t, q.size());
        end
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_obs();
        nvalid = 0; nrot = 0; max_cnt = 0; got_first = 1'b0; first_cd = 8'h00;
    endtask

    typedef struct {
        int           n;
        logic [159:0] bytes;      // right-aligned, first byte most significant
        int           gap;
        int           exp_valid;
        logic [7:0]   exp_first;
        logic         exp_ovf;
        int           exp_max;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl[NV];
    logic [7:0] alpha[8] = '{8'h1C, 8'h32, 8'h21, 8'hF0, 8'hE0, 8'hAA, 8'h75, 8'h23};

    initial begin
        reset = 1'b1; received_data_en = 1'b0; received_data = 8'h00;
        tbl[0] = '{3,  160'h1CF01C,       1, 1, 8'h51, 1'b0, 1};
        tbl[1] = '{5,  160'h1C1C1CF01C,   1, 1, 8'h51, 1'b0, 1};
        tbl[2] = '{5,  160'hE075E0F075,   1, 0, 8'h00, 1'b0, 0};
        tbl[3] = '{5,  160'hFAAA1CF01C,   1, 1, 8'h51, 1'b0, 1};
        tbl[4] = '{4,  160'h32F03221,     1, 2, 8'h7F, 1'b0, 1};
        tbl[5] = '{18, 160'h1CF01C32F03221F02123F02324F0242BF02B, 0, 5, 8'h51, 1'b1, 4};
        tbl[6] = '{4,  160'hE0F01C1C,     1, 1, 8'h51, 1'b0, 1};

        @(posedge CLOCK_50); #1;
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("reset_plain", plain_scan, 8'h00);
        chk("reset_flags", {3'b0, rotate, cipher_valid, busy, overflow, 1'b0}, 8'h00);

        for (int i = 0; i < NV; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            cyc(1'b1, 1'b0, 8'h00);
            clear_obs();
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(1'b0, 1'b1, tbl[i].bytes[8*(tbl[i].n-1-k) +: 8]);
                repeat (tbl[i].gap) cyc(1'b0, 1'b0, 8'h00);
            end
            drain();
            chk($sformatf("v%0d_valids", i), 8'(nvalid), 8'(tbl[i].exp_valid));
            chk($sformatf("v%0d_rotates", i), 8'(nrot), 8'(tbl[i].exp_valid));
            chk($sformatf("v%0d_overflow", i), {7'b0, overflow}, {7'b0, tbl[i].exp_ovf});
            chk($sformatf("v%0d_maxcount", i), 8'(max_cnt), 8'(tbl[i].exp_max));
            if (tbl[i].exp_valid > 0)
                chk($sformatf("v%0d_first", i), first_cd, tbl[i].exp_first);
        end

        // Reset landing in the settle window with two keys still queued.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        clear_obs();
        cyc(1'b0, 1'b1, 8'h1C);
        cyc(1'b0, 1'b1, 8'h32);
        cyc(1'b0, 1'b1, 8'h21);
        for (int k = 0; k < 100 && nrot == 0; k++) cyc(1'b0, 1'b0, 8'h00);
        chk("abort_rotate_seen", 8'(nrot), 8'd1);
        repeat (5) cyc(1'b0, 1'b0, 8'h00);
        chk("abort_queued", {5'b0, fifo_count}, 8'd2);
        cyc(1'b1, 1'b0, 8'h00);
        clear_obs();
        cyc(1'b0, 1'b0, 8'h00);
        chk("abort_fifo", {5'b0, fifo_count}, 8'd0);
        chk("abort_busy", {7'b0, busy}, 8'd0);
        chk("abort_overflow", {7'b0, overflow}, 8'd0);
        repeat (150) cyc(1'b0, 1'b0, 8'h00);
        chk("abort_no_rotate", 8'(nrot), 8'd0);
        chk("abort_no_valid", 8'(nvalid), 8'd0);

        // Random traffic from a small alphabet so repeats, breaks and overflow all occur.
        cyc(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 4000; k++)
            cyc(1'b0, ($urandom_range(0, 3) == 0), alpha[$urandom_range(0, 7)]);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/keystroke_scheduler.md
KEYSTROKE_SCHEDULER -- requirements
Module: keystroke_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 5000: idle cycles after each rotor step before the next keystroke is issued.
REQ-002 Parameter CORE_LATENCY, default 2: cycles from plain_scan change to valid encoded_data from the cipher core.
REQ-003 Parameter FIFO_DEPTH, default 4: keystroke queue depth; only 4 is required.
REQ-004 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 received_data  in  8  byte from the PS/2 controller.
REQ-007 received_data_en  in  1  single-cycle strobe qualifying received_data.
REQ-008 encoded_data  in  8  ASCII ciphertext from the cipher core (o_outputData).
REQ-009 plain_scan  out  8  registered scan code presented to scan-code-to-ASCII and the core.
REQ-010 rotate  out  1  one-cycle rotor-step pulse to the core.
REQ-011 cipher_data  out  8  last captured ciphertext, held until the next capture.
REQ-012 cipher_valid  out  1  one-cycle pulse when cipher_data updates.
REQ-013 busy  out  1  high whenever the sequencer is not in S_IDLE.
REQ-014 fifo_count  out  3  queued keystrokes, 0..4.
REQ-015 overflow  out  1  sticky flag; a keystroke was dropped.

Function
REQ-016 Parser states SHALL be P_IDLE, P_BREAK (after 0xF0) and P_EXT (after 0xE0); they advance only on cycles where received_data_en=1.
REQ-017 In P_IDLE: 0xF0 -> P_BREAK; 0xE0 -> P_EXT; 0xAA/0xFA/0xFE/0xEE are ignored; any other byte is a make code.
REQ-018 A make code not equal to held_key SHALL be pushed and stored in held_key; a make code equal to held_key (typematic repeat) is discarded.
REQ-019 In P_BREAK, the next byte SHALL clear held_key to 0x00 if equal, then return to P_IDLE; nothing is pushed.
REQ-020 In P_EXT, the next byte returns to P_IDLE (or goes to P_BREAK if 0xF0); extended keys are never pushed.
REQ-021 Queue: a push when full with no pop SHALL drop the byte and set overflow; a simultaneous push and pop when full SHALL accept both; a pop when empty is impossible by construction.
REQ-022 Sequencer states SHALL be S_IDLE, S_WAIT, S_CAPTURE, S_ROTATE and S_SETTLE.
REQ-023 S_IDLE with a non-empty queue at cycle T: pop, plain_scan<=head, -> S_WAIT; plain_scan is then stable until the next pop.
REQ-024 S_WAIT SHALL hold CORE_LATENCY cycles -> S_CAPTURE; cipher_data<=encoded_data and cipher_valid=1 in cycle T+CORE_LATENCY+1.
REQ-025 S_ROTATE: rotate=1 for exactly the cycle after cipher_valid -> S_SETTLE.
REQ-026 S_SETTLE SHALL count SETTLE_CYCLES cycles with rotate=0 -> S_IDLE; the next pop occurs no earlier than the following cycle.
REQ-027 Each queued keystroke SHALL produce exactly one cipher_valid and exactly one rotate pulse, in FIFO order.
REQ-028 The settle counter SHALL be wide enough for SETTLE_CYCLES without wrap; it reloads on each S_ROTATE entry.
REQ-029 Parser and queue SHALL keep accepting bytes while the sequencer is busy.

Reset
REQ-030 While reset=1: parser in P_IDLE, held_key=0x00, sequencer in S_IDLE, queue flushed, settle counter 0.
REQ-031 While reset=1: plain_scan=0x00, cipher_data=0x00, rotate=0, cipher_valid=0, busy=0, fifo_count=0, overflow=0.
REQ-032 A reset asserted mid-sequence SHALL abort it with no rotate or cipher_valid pulse issued afterwards.

Structure
REQ-033 A shared package enigma_ctrl_pkg SHALL hold the scan-code constants (0xF0, 0xE0, 0xAA, 0xFA, 0xFE, 0xEE) and the parser and sequencer state encodings.
REQ-034 The queue SHALL be the sub-module keystroke_fifo (depth 4, width 8, count output, synchronous reset).

Verification
REQ-035 Send bytes 1C, F0, 1C with CORE_LATENCY=2 and the core model returning 0x51 -> one cipher_valid, cipher_data=0x51, rotate one cycle later, busy low after SETTLE_CYCLES.
REQ-036 Send 1C, 1C, 1C, F0, 1C -> exactly one push, one cipher_valid and one rotate.
REQ-037 Send E0, 75, E0, F0, 75 -> no push; fifo_count stays 0; no rotate.
REQ-038 Send six distinct make/break pairs (1C, 32, 21, 23, 24, 2B) while busy -> fifo_count reaches 4, overflow=1, five or fewer cipher_valid pulses in input order.
REQ-039 Assert reset for one cycle during S_SETTLE with 2 keys queued -> fifo_count=0, busy=0, no further rotate, overflow=0.
REQ-040 Send FA, AA, then 1C, F0, 1C -> the first two bytes are ignored; one ciphertext is produced.
